// File: rtl/game_pkg.sv
// Shared sprite geometry and collision FSM encodings for the game logic.
package game_pkg;

    localparam int COORD_W = 11;

    localparam logic [COORD_W-1:0] MARIO_W      = 11'd34;
    localparam logic [COORD_W-1:0] MARIO_H      = 11'd36;
    localparam logic [COORD_W-1:0] QUEUE_W      = 11'd44;
    localparam logic [COORD_W-1:0] QUEUE_H      = 11'd50;
    localparam logic [COORD_W-1:0] QUEUE_HALF_W = 11'd22;
    localparam logic [COORD_W-1:0] QUEUE_HALF_H = 11'd25;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_INVULN  = 3'd3,
        ST_DEAD    = 3'd4,
        ST_WON     = 3'd5
    } judge_state_t;

    // Clamp at zero so a box near the screen edge never wraps to the far side.
    function automatic logic [COORD_W-1:0] sat_sub(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned box intersection in 11-bit unsigned arithmetic; shared edges do not count.
module box_overlap
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] a_w,
    input  logic [COORD_W-1:0] a_h,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W-1:0] b_w,
    input  logic [COORD_W-1:0] b_h,
    output logic               overlap
);

    // Operands are zero-extended 10/9-bit coordinates, so sums stay below 2^11.
    assign overlap = (a_x < b_x + b_w) && (b_x < a_x + a_w) &&
                     (a_y < b_y + b_h) && (b_y < a_y + a_h);

endmodule

// File: rtl/collision_judge.sv
// Mario collision judge: confirms barrel hits, tracks lives, flags game over / queue reached.
// COLLISION_INVULN_EN enables a timed post-hit grace period instead of waiting for overlap to clear.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | game not running; lives reloaded, flags clear
// ST_ARMED   | watching for queue or barrel overlap
// ST_CONFIRM | barrel overlapping, counting consecutive ticks
// ST_INVULN  | post-hit grace; barrel ignored
// ST_DEAD    | lives exhausted, over held high
// ST_WON     | queue reached, success held high
module collision_judge
    import game_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int CONFIRM_TICKS = 2,
    parameter int INVULN_TICKS  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       running,
    input  logic [9:0] mario_x,
    input  logic [8:0] mario_y,
    input  logic [9:0] barrel_x,
    input  logic [8:0] barrel_y,
    input  logic [9:0] barrel_w,
    input  logic [8:0] barrel_h,
    input  logic [9:0] queue_x,
    input  logic [8:0] queue_y,
    output logic       hit,
    output logic [1:0] lives,
    output logic       over,
    output logic       success
);

    localparam logic [1:0] LIVES_INIT   = 2'(LIVES);
    localparam logic [3:0] CONFIRM_LAST = 4'(CONFIRM_TICKS);

    logic [COORD_W-1:0] m_x, m_y;
    logic [COORD_W-1:0] q_cx, q_cy, q_left, q_top, q_w, q_h;
    logic               barrel_ov, queue_ov;
    logic               hit_now;

    judge_state_t state;
    logic [3:0]   confirm_cnt;
`ifdef COLLISION_INVULN_EN
    localparam logic [7:0] GRACE_LOAD = 8'(INVULN_TICKS);
    logic [7:0]   grace_cnt;
`endif

    assign m_x  = {1'b0, mario_x};
    assign m_y  = {2'b0, mario_y};
    assign q_cx = {1'b0, queue_x};
    assign q_cy = {2'b0, queue_y};

    // When the centre sits within half a sprite of the origin the box is clipped
    // at zero, keeping its right/bottom edge where the full sprite would put it.
    assign q_left = sat_sub(q_cx, QUEUE_HALF_W);
    assign q_top  = sat_sub(q_cy, QUEUE_HALF_H);
    assign q_w    = (q_cx >= QUEUE_HALF_W) ? QUEUE_W : (q_cx + (QUEUE_W - QUEUE_HALF_W));
    assign q_h    = (q_cy >= QUEUE_HALF_H) ? QUEUE_H : (q_cy + (QUEUE_H - QUEUE_HALF_H));

    box_overlap u_barrel_box (
        .a_x     (m_x),
        .a_y     (m_y),
        .a_w     (MARIO_W),
        .a_h     (MARIO_H),
        .b_x     ({1'b0, barrel_x}),
        .b_y     ({2'b0, barrel_y}),
        .b_w     ({1'b0, barrel_w}),
        .b_h     ({2'b0, barrel_h}),
        .overlap (barrel_ov)
    );

    box_overlap u_queue_box (
        .a_x     (m_x),
        .a_y     (m_y),
        .a_w     (MARIO_W),
        .a_h     (MARIO_H),
        .b_x     (q_left),
        .b_y     (q_top),
        .b_w     (q_w),
        .b_h     (q_h),
        .overlap (queue_ov)
    );

    // Queue overlap always outranks a barrel hit on the same tick.
    always_comb begin
        hit_now = 1'b0;
        case (state)
            ST_ARMED:   hit_now = !queue_ov && barrel_ov && (CONFIRM_LAST == 4'd1);
            ST_CONFIRM: hit_now = !queue_ov && barrel_ov && (confirm_cnt + 4'd1 == CONFIRM_LAST);
            default:    hit_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lives       <= LIVES_INIT;
            hit         <= 1'b0;
            over        <= 1'b0;
            success     <= 1'b0;
            confirm_cnt <= '0;
`ifdef COLLISION_INVULN_EN
            grace_cnt   <= '0;
`endif
        end else begin
            hit <= 1'b0;
            if (!running) begin
                state       <= ST_IDLE;
                lives       <= LIVES_INIT;
                over        <= 1'b0;
                success     <= 1'b0;
                confirm_cnt <= '0;
`ifdef COLLISION_INVULN_EN
                grace_cnt   <= '0;
`endif
            end else if (tick) begin
                if (hit_now) begin
                    hit         <= 1'b1;
                    lives       <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                    confirm_cnt <= '0;
                    if (lives <= 2'd1) begin
                        state <= ST_DEAD;
                        over  <= 1'b1;
                    end else begin
                        state <= ST_INVULN;
`ifdef COLLISION_INVULN_EN
                        grace_cnt <= GRACE_LOAD;
`endif
                    end
                end else begin
                    case (state)
                        ST_IDLE: begin
                            state <= ST_ARMED;
                            lives <= LIVES_INIT;
                        end
                        ST_ARMED: begin
                            if (queue_ov) begin
                                state   <= ST_WON;
                                success <= 1'b1;
                            end else if (barrel_ov) begin
                                state       <= ST_CONFIRM;
                                confirm_cnt <= 4'd1;
                            end
                        end
                        ST_CONFIRM: begin
                            if (queue_ov) begin
                                state       <= ST_WON;
                                success     <= 1'b1;
                                confirm_cnt <= '0;
                            end else if (barrel_ov) begin
                                confirm_cnt <= confirm_cnt + 4'd1;
                            end else begin
                                state       <= ST_ARMED;
                                confirm_cnt <= '0;
                            end
                        end
                        ST_INVULN: begin
                            if (queue_ov) begin
                                state   <= ST_WON;
                                success <= 1'b1;
`ifdef COLLISION_INVULN_EN
                                grace_cnt <= '0;
                            end else if (grace_cnt == 8'd1) begin
                                state     <= ST_ARMED;
                                grace_cnt <= '0;
                            end else begin
                                grace_cnt <= grace_cnt - 8'd1;
                            end
`else
                            end else if (!barrel_ov) begin
                                state <= ST_ARMED;
                            end
`endif
                        end
                        ST_DEAD: state <= ST_DEAD;
                        ST_WON:  state <= ST_WON;
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_judge.sv
// Directed-vector bench for collision_judge with hand-computed expectations.
module tb_collision_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       running = 1'b0;
    logic [9:0] mario_x = 10'd100, barrel_x = 10'd600, barrel_w = 10'd32, queue_x = 10'd900;
    logic [8:0] mario_y = 9'd100, barrel_y = 9'd400, barrel_h = 9'd24, queue_y = 9'd400;
    logic       hit;
    logic [1:0] lives;
    logic       over;
    logic       success;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    collision_judge dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .running  (running),
        .mario_x  (mario_x),
        .mario_y  (mario_y),
        .barrel_x (barrel_x),
        .barrel_y (barrel_y),
        .barrel_w (barrel_w),
        .barrel_h (barrel_h),
        .queue_x  (queue_x),
        .queue_y  (queue_y),
        .hit      (hit),
        .lives    (lives),
        .over     (over),
        .success  (success)
    );

    // One clock with tick driven to t; returns 1 time unit after the edge with tick low.
    task automatic step(input logic t);
        @(negedge clk);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic barrel_away();
        barrel_x = 10'd600; barrel_y = 9'd400;
        queue_x  = 10'd900; queue_y  = 9'd400;
    endtask

    task automatic clear_invuln();
        barrel_away();
        repeat (40) step(1'b1);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (lives !== 2'd3) begin n_err++; $display("FAIL reset_lives: got %0d want 3", lives); end
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", hit); end
        n_vec++; if (over !== 1'b0) begin n_err++; $display("FAIL reset_over: got %b want 0", over); end
        n_vec++; if (success !== 1'b0) begin n_err++; $display("FAIL reset_success: got %b want 0", success); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_tick();
        running = 1'b1;
        mario_x = 10'd100; mario_y = 9'd100;
        barrel_away();
        step(1'b1);
        barrel_x = 10'd133; barrel_y = 9'd100;
        step(1'b1);
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL single_first: hit got %b want 0", hit); end
        barrel_away();
        step(1'b1);
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL single_clear: hit got %b want 0", hit); end
        barrel_x = 10'd133; barrel_y = 9'd100;
        step(1'b1);
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL single_restart: hit got %b want 0", hit); end
        barrel_away();
        step(1'b1);
        n_vec++; if (lives !== 2'd3) begin n_err++; $display("FAIL single_lives: got %0d want 3", lives); end
    endtask

    task automatic test_hit_boundary();
        int hits;
        hits = 0;
        barrel_x = 10'd134; barrel_y = 9'd100;
        repeat (3) begin step(1'b1); if (hit === 1'b1) hits++; end
        barrel_x = 10'd120; barrel_y = 9'd136;
        repeat (3) begin step(1'b1); if (hit === 1'b1) hits++; end
        n_vec++; if (hits != 0) begin n_err++; $display("FAIL touch_edges: hits got %0d want 0", hits); end
        barrel_x = 10'd133; barrel_y = 9'd100;
        step(1'b1);
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL confirm_tick1: hit got %b want 0", hit); end
        step(1'b1);
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL confirm_tick2: hit got %b want 1", hit); end
        n_vec++; if (lives !== 2'd2) begin n_err++; $display("FAIL first_hit_lives: got %0d want 2", lives); end
        step(1'b0);
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL hit_pulse: got %b want 0", hit); end
    endtask

    task automatic test_invuln();
`ifdef COLLISION_INVULN_EN
        int gap;
        bit found;
        gap = 0;
        found = 1'b0;
        for (int k = 1; k <= 100 && !found; k++) begin
            step(1'b1);
            if (hit === 1'b1) begin found = 1'b1; gap = k; end
        end
        n_vec++; if (gap != 34) begin n_err++; $display("FAIL grace_gap: ticks got %0d want 34", gap); end
        n_vec++; if (lives !== 2'd1) begin n_err++; $display("FAIL grace_lives: got %0d want 1", lives); end
        clear_invuln();
`else
        int hits;
        hits = 0;
        repeat (40) begin step(1'b1); if (hit === 1'b1) hits++; end
        n_vec++; if (hits != 0) begin n_err++; $display("FAIL invuln_hold: hits got %0d want 0", hits); end
        n_vec++; if (lives !== 2'd2) begin n_err++; $display("FAIL invuln_lives: got %0d want 2", lives); end
        barrel_away();
        step(1'b1);
        barrel_x = 10'd133; barrel_y = 9'd100;
        step(1'b1);
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL rearm_tick1: hit got %b want 0", hit); end
        step(1'b1);
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL rearm_tick2: hit got %b want 1", hit); end
        n_vec++; if (lives !== 2'd1) begin n_err++; $display("FAIL rearm_lives: got %0d want 1", lives); end
        clear_invuln();
`endif
    endtask

    task automatic test_dead();
        int bad;
        bad = 0;
        barrel_x = 10'd133; barrel_y = 9'd100;
        step(1'b1);
        step(1'b1);
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL last_hit: got %b want 1", hit); end
        n_vec++; if (lives !== 2'd0) begin n_err++; $display("FAIL dead_lives: got %0d want 0", lives); end
        n_vec++; if (over !== 1'b1) begin n_err++; $display("FAIL dead_over: got %b want 1", over); end
        repeat (6) begin
            step(1'b1);
            if (over !== 1'b1 || lives !== 2'd0 || hit !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL dead_sticky: bad ticks got %0d want 0", bad); end
        running = 1'b0;
        step(1'b0);
        n_vec++; if (over !== 1'b0) begin n_err++; $display("FAIL stop_over: got %b want 0", over); end
        n_vec++; if (lives !== 2'd3) begin n_err++; $display("FAIL stop_lives: got %0d want 3", lives); end
    endtask

    task automatic test_queue_priority();
        int bad;
        bad = 0;
        running = 1'b1;
        mario_x = 10'd100; mario_y = 9'd100;
        barrel_away();
        step(1'b1);
        queue_x = 10'd156; queue_y = 9'd130;
        step(1'b1);
        n_vec++; if (success !== 1'b0) begin n_err++; $display("FAIL queue_touch: success got %b want 0", success); end
        queue_x = 10'd155;
        barrel_x = 10'd133; barrel_y = 9'd100;
        step(1'b1);
        n_vec++; if (success !== 1'b1) begin n_err++; $display("FAIL queue_win: success got %b want 1", success); end
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL queue_nohit: hit got %b want 0", hit); end
        n_vec++; if (lives !== 2'd3) begin n_err++; $display("FAIL queue_lives: got %0d want 3", lives); end
        barrel_away();
        repeat (3) begin step(1'b1); if (success !== 1'b1) bad++; end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL won_sticky: bad ticks got %0d want 0", bad); end
        running = 1'b0;
        step(1'b0);
        n_vec++; if (success !== 1'b0) begin n_err++; $display("FAIL stop_success: got %b want 0", success); end
        running = 1'b1;
        step(1'b1);
        mario_x = 10'd0; mario_y = 9'd0;
        queue_x = 10'd10; queue_y = 9'd10;
        step(1'b1);
        n_vec++; if (success !== 1'b1) begin n_err++; $display("FAIL queue_origin: success got %b want 1", success); end
        running = 1'b0;
        barrel_away();
        mario_x = 10'd100; mario_y = 9'd100;
        step(1'b0);
    endtask

    task automatic test_reset_mid_confirm();
        running = 1'b1;
        step(1'b1);
        barrel_x = 10'd133; barrel_y = 9'd100;
        step(1'b1);
        step(1'b1);
        n_vec++; if (lives !== 2'd2) begin n_err++; $display("FAIL pre_rst_lives: got %0d want 2", lives); end
        clear_invuln();
        barrel_x = 10'd133; barrel_y = 9'd100;
        step(1'b1);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (lives !== 2'd3) begin n_err++; $display("FAIL async_rst_lives: got %0d want 3", lives); end
        n_vec++; if (over !== 1'b0 || success !== 1'b0) begin n_err++; $display("FAIL async_rst_flags: over %b success %b want 0 0", over, success); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        n_vec++; if (hit !== 1'b1) begin n_err++; $display("FAIL post_rst_hit: got %b want 1", hit); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (hit !== 1'b0) begin n_err++; $display("FAIL async_rst_hit: got %b want 0", hit); end
        n_vec++; if (lives !== 2'd3) begin n_err++; $display("FAIL async_rst_lives2: got %0d want 3", lives); end
        @(negedge clk);
        rst = 1'b0;
        running = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_tick();
        test_hit_boundary();
        test_invuln();
        test_dead();
        test_queue_priority();
        test_reset_mid_confirm();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1);
    end

endmodule
